// File: rtl/fifo_rr_drain_arb.sv
// fifo_rr_drain_arb: round-robin drain of NUM_SRC fifos into one valid/ready sink with burst fairness
module fifo_rr_drain_arb #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_empty,
  output logic [NUM_SRC-1:0]          src_pop,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]  out_src,
  output logic                        busy
);
  localparam int SW = $clog2(NUM_SRC);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [SW-1:0] g, g_n, rr, rr_n, fl_src, g_inc;
  logic [3:0] burst, burst_n;
  logic run, fl, hs, credit, pop_en, others, at_max;
  logic [1:0] occ;
  logic [2:0] owed;
  logic rd_ptr, wr_ptr;
  logic [NUM_SRC-1:0] ne;
  logic [SW:0] idle_f, rel_f;
  logic [DATA_W-1:0] sd [NUM_SRC];
  logic [DATA_W-1:0] buf_data [2];
  logic [SW-1:0] buf_src [2];
  // first non-empty source at or after start, wrapping; msb flags a hit
  function automatic logic [SW:0] find(input logic [NUM_SRC-1:0] nev, input int start);
    int j;
    find = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = (start + k) % NUM_SRC;
      if (nev[j]) find = {1'b1, SW'(j)};
    end
  endfunction
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign sd[i] = src_data[i*DATA_W +: DATA_W];
  end
  assign ne = ~src_empty;
  assign hs = out_valid & out_ready;
  assign owed = {1'b0, occ} + {2'b0, fl} - {2'b0, hs};
  assign credit = owed < 3'd2;
  assign g_inc = (g == SW'(NUM_SRC - 1)) ? '0 : g + 1'b1;
  assign idle_f = find(ne, int'(rr));
  assign rel_f = find(ne, int'(g_inc));
  assign others = |(ne & ~(NUM_SRC'(1) << g));
  assign at_max = burst == 4'(MAX_BURST);
  always_comb begin
    state_n = state;
    g_n = g;
    rr_n = rr;
    burst_n = burst;
    pop_en = 1'b0;
    if (run && state == IDLE) begin
      if (idle_f[SW] && credit) begin
        state_n = GRANT;
        g_n = idle_f[SW-1:0];
        pop_en = 1'b1;
        burst_n = 4'd1;
      end
    end else if (run && (!ne[g] || (at_max && others))) begin
      rr_n = g_inc;
      if (rel_f[SW] && credit) begin
        g_n = rel_f[SW-1:0];
        pop_en = 1'b1;
        burst_n = 4'd1;
      end else begin
        state_n = IDLE;
        burst_n = 4'd0;
      end
    end else if (run && credit) begin
      pop_en = 1'b1;
      burst_n = at_max ? 4'd1 : burst + 4'd1;
    end
  end
  assign src_pop = pop_en ? NUM_SRC'(1) << g_n : '0;
  assign out_valid = occ != 2'd0;
  assign out_data = buf_data[rd_ptr];
  assign out_src = buf_src[rd_ptr];
  assign busy = (state == GRANT) | fl | out_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      state <= IDLE;
      g <= '0;
      rr <= '0;
      burst <= '0;
      fl <= 1'b0;
      fl_src <= '0;
      occ <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_src[0] <= '0;
      buf_src[1] <= '0;
    end else begin
      run <= 1'b1;
      state <= state_n;
      g <= g_n;
      rr <= rr_n;
      burst <= burst_n;
      fl <= pop_en;
      fl_src <= g_n;
      occ <= occ + {1'b0, fl} - {1'b0, hs};
      if (fl) begin
        buf_data[wr_ptr] <= sd[fl_src];
        buf_src[wr_ptr] <= fl_src;
        wr_ptr <= ~wr_ptr;
      end
      if (hs) rd_ptr <= ~rd_ptr;
    end
  end
endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// tb_fifo_rr_drain_arb: directed checks of the round-robin fifo drain arbiter
module tb_fifo_rr_drain_arb;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
  logic [1:0] src_empty, src_pop;
  logic [15:0] src_data;
  logic out_valid, busy, out_src;
  logic [7:0] out_data;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem [2][256];
  logic [7:0] rp [2] = '{8'd0, 8'd0};
  logic [7:0] wp [2] = '{8'd0, 8'd0};
  logic [7:0] dreg [2] = '{8'd0, 8'd0};
  int cyc = 0, pop_cnt, pop_bad, first_pop, last_pop, first_valid, outst = 0, max_outst, valid_cnt, busy_cnt;
  logic [1:0] pop_log [$];
  int pop_cyc [$];
  logic got_src [$], exp_src [$];
  logic [7:0] got_data [$], exp_data [$];

  fifo_rr_drain_arb #(.NUM_SRC(2), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_empty(src_empty), .src_pop(src_pop), .src_data(src_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;
  assign src_empty = {rp[1] == wp[1], rp[0] == wp[0]};
  assign src_data = {dreg[1], dreg[0]};
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (src_pop[i]) begin
        dreg[i] <= mem[i][rp[i]];
        rp[i] <= rp[i] + 8'd1;
      end

  task automatic load(input int s, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      mem[s][wp[s]] = base + 8'(k);
      wp[s] = wp[s] + 8'd1;
    end
  endtask

  task automatic clear();
    pop_cnt = 0; pop_bad = 0; first_pop = -1; last_pop = -1; first_valid = -1;
    max_outst = 0; outst = 0; valid_cnt = 0; busy_cnt = 0;
    pop_log.delete(); pop_cyc.delete(); got_src.delete(); got_data.delete(); exp_src.delete(); exp_data.delete();
  endtask

  task automatic step(input logic rdy);
    logic h;
    @(negedge clk);
    out_ready = rdy;
    #1;
    cyc++;
    h = out_valid & out_ready;
    if (outst > max_outst) max_outst = outst;
    if (out_valid) begin valid_cnt++; if (first_valid < 0) first_valid = cyc; end
    if (busy) busy_cnt++;
    if (h) begin got_src.push_back(out_src); got_data.push_back(out_data); end
    if (src_pop != 2'b00) begin
      if ((src_pop & src_empty) != 2'b00 || src_pop == 2'b11 || outst - int'(h) >= 2) pop_bad++;
      pop_cnt++; pop_log.push_back(src_pop); pop_cyc.push_back(cyc);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    outst = outst + int'(src_pop != 2'b00) - int'(h);
  endtask

  task automatic run_until(input int n, input int budget, input bit toggle);
    for (int k = 0; k < budget && got_data.size() < n; k++) step(toggle ? k % 2 == 0 : 1'b1);
  endtask

  task automatic expect_word(input logic s, input logic [7:0] d);
    exp_src.push_back(s); exp_data.push_back(d);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (src_pop !== 2'b00) begin n_bad++; $display("FAIL rst_pop: got %b expected 00", src_pop); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h expected 00", out_data); end
    n_cmp++; if (out_src !== 1'b0) begin n_bad++; $display("FAIL rst_src: got %b expected 0", out_src); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    clear();
    repeat (10) step(1'b1);
    n_cmp++; if (pop_cnt !== 0) begin n_bad++; $display("FAIL idle_pops: got %0d expected 0", pop_cnt); end
    n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL idle_valid: got %0d expected 0", valid_cnt); end
    n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL idle_busy: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    clear();
    for (int k = 0; k < 16; k++) expect_word(1'b0, 8'h10 + 8'(k));
    @(posedge clk); #1;
    load(0, 8'h10, 16);
    run_until(16, 60, 1'b0);
    n_cmp++; if (got_data.size() != 16) begin n_bad++; $display("FAIL b2b_count: got %0d expected 16", got_data.size()); end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_data[i] || got_src[i] !== exp_src[i]) begin n_bad++; $display("FAIL b2b_word%0d: got src%0d %h expected src%0d %h", i, got_src[i], got_data[i], exp_src[i], exp_data[i]); end
    end
    n_cmp++; if (pop_cnt !== 16) begin n_bad++; $display("FAIL b2b_pops: got %0d expected 16", pop_cnt); end
    n_cmp++; if (last_pop - first_pop !== 15) begin n_bad++; $display("FAIL b2b_span: got %0d expected 15", last_pop - first_pop); end
    n_cmp++; if (first_valid - first_pop !== 2) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 2", first_valid - first_pop); end
    n_cmp++; if (pop_bad !== 0) begin n_bad++; $display("FAIL b2b_pop_rules: got %0d expected 0", pop_bad); end
    step(1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_drop: got %b expected 0", busy); end
  endtask

  task automatic test_fairness(input bit toggle);
    int a = 0, b = 0;
    clear();
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 4; k++) begin expect_word(1'b0, 8'hA0 + 8'(a)); a++; end
      for (int k = 0; k < 4; k++) begin expect_word(1'b1, 8'hB0 + 8'(b)); b++; end
    end
    for (int k = 0; k < 4; k++) begin expect_word(1'b0, 8'hA0 + 8'(a)); a++; end
    @(posedge clk); #1;
    load(0, 8'hA0, 20);
    step(1'b1);
    @(posedge clk); #1;
    load(1, 8'hB0, 16);
    run_until(36, 400, toggle);
    n_cmp++; if (got_data.size() != 36) begin n_bad++; $display("FAIL fair%0d_count: got %0d expected 36", toggle, got_data.size()); end
    for (int i = 0; i < 36 && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_data[i] || got_src[i] !== exp_src[i]) begin n_bad++; $display("FAIL fair%0d_word%0d: got src%0d %h expected src%0d %h", toggle, i, got_src[i], got_data[i], exp_src[i], exp_data[i]); end
    end
    n_cmp++; if (pop_cnt !== 36) begin n_bad++; $display("FAIL fair%0d_pops: got %0d expected 36", toggle, pop_cnt); end
    n_cmp++; if (pop_bad !== 0) begin n_bad++; $display("FAIL fair%0d_pop_rules: got %0d expected 0", toggle, pop_bad); end
    n_cmp++; if (max_outst > 2) begin n_bad++; $display("FAIL fair%0d_occupancy: got %0d expected <=2", toggle, max_outst); end
  endtask

  task automatic test_release_no_bubble();
    clear();
    expect_word(1'b1, 8'hE0);
    for (int k = 0; k < 8; k++) expect_word(1'b0, 8'h60 + 8'(k));
    @(posedge clk); #1;
    load(1, 8'hE0, 1);
    load(0, 8'h60, 8);
    run_until(9, 60, 1'b0);
    n_cmp++; if (pop_log[0] !== 2'b10) begin n_bad++; $display("FAIL rel_first_pop: got %b expected 10", pop_log[0]); end
    n_cmp++; if (pop_log[1] !== 2'b01) begin n_bad++; $display("FAIL rel_second_pop: got %b expected 01", pop_log[1]); end
    n_cmp++; if (pop_cyc[1] - pop_cyc[0] !== 1) begin n_bad++; $display("FAIL rel_bubble: got gap %0d expected 1", pop_cyc[1] - pop_cyc[0]); end
    n_cmp++; if (got_data.size() != 9) begin n_bad++; $display("FAIL rel_count: got %0d expected 9", got_data.size()); end
    for (int i = 0; i < 9 && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_data[i] || got_src[i] !== exp_src[i]) begin n_bad++; $display("FAIL rel_word%0d: got src%0d %h expected src%0d %h", i, got_src[i], got_data[i], exp_src[i], exp_data[i]); end
    end
    n_cmp++; if (pop_bad !== 0) begin n_bad++; $display("FAIL rel_pop_rules: got %0d expected 0", pop_bad); end
  endtask

  task automatic test_reset_mid_burst();
    clear();
    @(posedge clk); #1;
    load(1, 8'hC0, 6);
    step(1'b0);
    step(1'b0);
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hC0) begin n_bad++; $display("FAIL pre_rst_head: got %b/%h expected 1/c0", out_valid, out_data); end
    rst_n = 1'b0;
    load(0, 8'hD0, 4);
    #1;
    n_cmp++; if ({src_pop, out_valid, out_data, out_src, busy} !== 12'h000) begin n_bad++; $display("FAIL async_rst: got pop %b v %b d %h s %b busy %b expected all 0", src_pop, out_valid, out_data, out_src, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (src_pop !== 2'b00) begin n_bad++; $display("FAIL rst_release_pop: got %b expected 00", src_pop); end
    clear();
    for (int k = 0; k < 4; k++) expect_word(1'b0, 8'hD0 + 8'(k));
    for (int k = 2; k < 6; k++) expect_word(1'b1, 8'hC0 + 8'(k));
    run_until(8, 60, 1'b0);
    n_cmp++; if (pop_log[0] !== 2'b01) begin n_bad++; $display("FAIL post_rst_first_pop: got %b expected 01", pop_log[0]); end
    n_cmp++; if (got_data.size() != 8) begin n_bad++; $display("FAIL post_rst_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_data[i] || got_src[i] !== exp_src[i]) begin n_bad++; $display("FAIL post_rst_word%0d: got src%0d %h expected src%0d %h", i, got_src[i], got_data[i], exp_src[i], exp_data[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fairness(1'b0);
    test_fairness(1'b1);
    test_release_no_bubble();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
